// File: rtl/la_checkpoint_driver.sv
// -----------------------------------------------------------------------------
// la_checkpoint_driver
//
// Purpose:
//   Firmware pushes 16-bit checkpoint words over the logic analyzer into a small
//   FIFO. Each word is presented on the user IOs for at least HOLD_CYCLES clocks,
//   so back-to-back checkpoints are never lost to a slow pin monitor. The current
//   word, FIFO level, busy and overflow flags are reflected back on la_data_out.
//
// Parameters:
//   DEPTH        FIFO entries, 1..7 (level must fit in la_data_out[18:16])
//   HOLD_CYCLES  minimum clocks each word stays on io_out, >= 1
//   IO_LSB       lowest mprj_io bit driven, IO_LSB+15 <= 37
//
// Ports:
//   clock        in   user clock (same domain as the LA)
//   resetb       in   async active-low reset; asserts asynchronously and is
//                     released synchronously to clock by an internal synchronizer
//   la_data_in   in   [15:0] word, [16] push (rising edge), [17] clear (level)
//   la_oenb      in   LA output enables, active-low; bit 16/17 low = LA drives it
//   la_data_out  out  [15:0] current word, [18:16] level, [19] busy,
//                     [20] overflow, [31:21] zero
//   io_out       out  checkpoint word on [IO_LSB+15:IO_LSB], zero elsewhere
//   io_oeb       out  0 (output) on [IO_LSB+15:IO_LSB], 1 elsewhere
// -----------------------------------------------------------------------------
module la_checkpoint_driver #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int IO_LSB      = 16
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic [31:0] la_data_in,
    input  logic [31:0] la_oenb,
    output logic [31:0] la_data_out,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [2:0]       DEPTH_C     = 3'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(DEPTH - 1);
    localparam logic [TMR_W-1:0] HOLD_RELOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [37:0]      IO_MASK     = 38'hFFFF << IO_LSB;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Reset synchronizer: resetb drops all state immediately, but release is
    // aligned to clock so no flop sees a reset edge near the active clock edge.
    // -------------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // -------------------------------------------------------------------------
    // Input qualification.
    //
    // Transfer semantics: there is no ready/backpressure. A push is a single
    // rising edge of the qualified push bit (a held-high bit counts once) and
    // carries la_data_in[15:0] from that same cycle. A push that finds the FIFO
    // full with no simultaneous pop is dropped and latches the sticky overflow
    // flag; firmware polls level/overflow on la_data_out to pace itself. Clear
    // is level-sensitive and overrides everything, including a same-cycle push.
    // -------------------------------------------------------------------------
    logic push_v;
    logic clear_v;
    logic push_ev;
    logic push_prev_q;

    assign push_v  = la_data_in[16] & ~la_oenb[16];
    assign clear_v = la_data_in[17] & ~la_oenb[17];
    assign push_ev = push_v & ~push_prev_q & ~clear_v;

    // Bits of the LA bus this block does not consume.
    logic unused_la;
    assign unused_la = ^{la_data_in[31:18], la_oenb[31:18], la_oenb[15:0]};

    // -------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // -------------------------------------------------------------------------
    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [2:0]       count_q;
    logic             overflow_q;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_acc;
    logic ovf_set;

    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == DEPTH_C);

    // A pop in the same cycle frees a slot, so a push into a full FIFO still
    // lands when the FSM is taking a word out.
    assign push_acc = push_ev & (~fifo_full | pop);
    assign ovf_set  = push_ev & fifo_full & ~pop;

    // -------------------------------------------------------------------------
    // Hold FSM
    // -------------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic [TMR_W-1:0]  timer_q;
    logic [TMR_W-1:0]  timer_d;
    logic [15:0]       cur_word_q;
    logic [15:0]       cur_word_d;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            cur_word_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cur_word_q <= cur_word_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cur_word_d = cur_word_q;
        pop        = 1'b0;

        if (clear_v) begin
            state_d    = IDLE;
            timer_d    = '0;
            cur_word_d = 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        cur_word_d = mem[rd_ptr_q];
                        timer_d    = HOLD_RELOAD;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    // The timer is loaded with HOLD_CYCLES-1 on the pop edge and
                    // the next pop happens on the edge after it reaches zero,
                    // giving exactly HOLD_CYCLES clocks per word when queued.
                    if (timer_q != '0) begin
                        timer_d = timer_q - TMR_W'(1);
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                        cur_word_d = mem[rd_ptr_q];
                        timer_d    = HOLD_RELOAD;
                    end else begin
                        // Last checkpoint stays on the pins.
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FIFO pointer, level, edge-detect and overflow registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= 3'd0;
            overflow_q  <= 1'b0;
            push_prev_q <= 1'b0;
        end else begin
            // Edge history tracks the qualified bit even during clear, so a push
            // held across a clear does not fire again afterwards.
            push_prev_q <= push_v;

            if (clear_v) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= 3'd0;
                overflow_q <= 1'b0;
            end else begin
                if (push_acc) begin
                    wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
                end
                case ({push_acc, pop})
                    2'b10:   count_q <= count_q + 3'd1;
                    2'b01:   count_q <= count_q - 3'd1;
                    default: count_q <= count_q;
                endcase
                if (ovf_set) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    // Storage is not reset: entries are only read once the level says valid.
    always_ff @(posedge clock) begin
        if (push_acc) begin
            mem[wr_ptr_q] <= la_data_in[15:0];
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: derived from registers only, no path from la_data_in.
    // -------------------------------------------------------------------------
    logic busy;
    assign busy = (state_q == HOLD);

    assign la_data_out = {11'b0, overflow_q, busy, count_q, cur_word_q};

    always_comb begin
        io_out                 = '0;
        io_out[IO_LSB +: 16]   = cur_word_q;
    end

    assign io_oeb = ~IO_MASK;

endmodule

// File: tb/tb_la_checkpoint_driver.sv
// -----------------------------------------------------------------------------
// tb_la_checkpoint_driver
//
// Directed bench for la_checkpoint_driver with default parameters
// (DEPTH=4, HOLD_CYCLES=16, IO_LSB=16). Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a period from the active edge.
// -----------------------------------------------------------------------------
module tb_la_checkpoint_driver;

    // ---------------------------------------------------------------- clock/reset
    logic        clock = 1'b0;
    logic        resetb;
    logic [31:0] la_data_in;
    logic [31:0] la_oenb;
    logic [31:0] la_data_out;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    always #5 clock = ~clock;

    localparam logic [31:0] OENB_DRIVE    = 32'hFFFC_FFFF;  // bits 16,17 driven
    localparam logic [31:0] OENB_NO_PUSH  = 32'hFFFD_FFFF;  // bit 16 not driven
    localparam logic [31:0] OENB_NO_CLEAR = 32'hFFFE_FFFF;  // bit 17 not driven
    localparam logic [37:0] OEB_EXP       = 38'h3F_0000_FFFF;

    la_checkpoint_driver dut (
        .clock       (clock),
        .resetb      (resetb),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .io_out      (io_out),
        .io_oeb      (io_oeb)
    );

    // ---------------------------------------------------------------- scoreboard
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [37:0] got,
                             input logic [37:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] io_word();
        return io_out[31:16];
    endfunction

    function automatic logic [2:0] level();
        return la_data_out[18:16];
    endfunction

    function automatic logic busy();
        return la_data_out[19];
    endfunction

    function automatic logic ovf();
        return la_data_out[20];
    endfunction

    // ---------------------------------------------------------------- drivers
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive(input logic [15:0] word, input logic push,
                         input logic clear);
        la_data_in = {14'b0, clear, push, word};
    endtask

    // One push edge then release: two clocks.
    task automatic push_word(input logic [15:0] word);
        drive(word, 1'b1, 1'b0);
        cyc(1);
        drive(word, 1'b0, 1'b0);
        cyc(1);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        resetb     = 1'b0;
        la_oenb    = OENB_DRIVE;
        drive(16'h0000, 1'b0, 1'b0);

        // 1. Reset values
        cyc(2);
        check_val("rst_io_out", io_out, 38'h0);
        check_val("rst_io_oeb", io_oeb, OEB_EXP);
        check_val("rst_la_out", 38'(la_data_out), 38'h0);
        resetb = 1'b1;
        cyc(4);
        check_val("post_rst_la_out", 38'(la_data_out), 38'h0);

        // 2. AB60 then AB61 three clocks later; exact hold window
        drive(16'hAB60, 1'b1, 1'b0);
        cyc(1);                                           // P0: enqueued
        check_val("t2_lvl_p0", 38'(level()), 38'd1);
        check_val("t2_io_p0", 38'(io_word()), 38'h0);
        drive(16'hAB60, 1'b0, 1'b0);
        cyc(1);                                           // P1: shown
        check_val("t2_io_p1", 38'(io_word()), 38'hAB60);
        check_val("t2_busy_p1", 38'(busy()), 38'd1);
        cyc(1);                                           // P2
        drive(16'hAB61, 1'b1, 1'b0);
        cyc(1);                                           // P3: AB61 enqueued
        drive(16'hAB61, 1'b0, 1'b0);
        check_val("t2_lvl_p3", 38'(level()), 38'd1);
        cyc(13);                                          // P16
        check_val("t2_io_p16", 38'(io_word()), 38'hAB60);
        cyc(1);                                           // P17
        check_val("t2_io_p17", 38'(io_word()), 38'hAB61);
        check_val("t2_lvl_p17", 38'(level()), 38'd0);
        cyc(15);                                          // P32
        check_val("t2_busy_p32", 38'(busy()), 38'd1);
        cyc(1);                                           // P33
        check_val("t2_busy_p33", 38'(busy()), 38'd0);
        check_val("t2_io_keep", 38'(io_word()), 38'hAB61);

        // 3. Overflow: W0 holding, push five more into a 4-deep FIFO
        push_word(16'h3000);                              // Q0..Q1
        check_val("t3_io_w0", 38'(io_word()), 38'h3000);
        for (int i = 1; i <= 4; i++) push_word(16'h3000 + 16'(i));
        check_val("t3_lvl_full", 38'(level()), 38'd4);
        check_val("t3_ovf_before", 38'(ovf()), 38'd0);
        push_word(16'h3005);                              // dropped at Q10
        check_val("t3_lvl_after", 38'(level()), 38'd4);
        check_val("t3_ovf_after", 38'(ovf()), 38'd1);
        check_val("t3_io_q11", 38'(io_word()), 38'h3000);
        cyc(5);                                           // Q16
        check_val("t3_io_q16", 38'(io_word()), 38'h3000);
        cyc(1);                                           // Q17
        check_val("t3_io_w1", 38'(io_word()), 38'h3001);
        check_val("t3_lvl_w1", 38'(level()), 38'd3);
        cyc(15);                                          // Q32
        check_val("t3_io_q32", 38'(io_word()), 38'h3001);
        cyc(1);                                           // Q33
        check_val("t3_io_w2", 38'(io_word()), 38'h3002);
        cyc(16);                                          // Q49
        check_val("t3_io_w3", 38'(io_word()), 38'h3003);
        cyc(16);                                          // Q65
        check_val("t3_io_w4", 38'(io_word()), 38'h3004);
        check_val("t3_lvl_w4", 38'(level()), 38'd0);
        cyc(16);                                          // Q81
        check_val("t3_busy_end", 38'(busy()), 38'd0);
        check_val("t3_io_end", 38'(io_word()), 38'h3004);
        check_val("t3_ovf_sticky", 38'(ovf()), 38'd1);

        drive(16'h0000, 1'b0, 1'b1);
        cyc(1);
        check_val("t3_clr_la_out", 38'(la_data_out), 38'h0);
        drive(16'h0000, 1'b0, 1'b0);
        cyc(1);

        // 4. Push bit held for 50 clocks: one word only
        drive(16'h5A5A, 1'b1, 1'b0);
        cyc(1);                                           // R0
        check_val("t4_lvl_r0", 38'(level()), 38'd1);
        cyc(1);                                           // R1
        check_val("t4_io_r1", 38'(io_word()), 38'h5A5A);
        check_val("t4_lvl_r1", 38'(level()), 38'd0);
        cyc(18);                                          // R19
        check_val("t4_busy_r19", 38'(busy()), 38'd0);
        drive(16'h1111, 1'b1, 1'b0);                      // word changes, push held
        cyc(30);                                          // R49
        check_val("t4_io_r49", 38'(io_word()), 38'h5A5A);
        check_val("t4_lvl_r49", 38'(level()), 38'd0);
        check_val("t4_busy_r49", 38'(busy()), 38'd0);
        drive(16'h0000, 1'b0, 1'b0);
        cyc(1);

        // 5a. Push toggled while LA does not drive bit 16
        la_oenb = OENB_NO_PUSH;
        for (int i = 0; i < 6; i++) begin
            drive(16'h7777, (i % 2) == 0, 1'b0);
            cyc(1);
        end
        check_val("t5_mask_lvl", 38'(level()), 38'd0);
        check_val("t5_mask_busy", 38'(busy()), 38'd0);
        check_val("t5_mask_io", 38'(io_word()), 38'h5A5A);
        drive(16'h0000, 1'b0, 1'b0);
        la_oenb = OENB_DRIVE;
        cyc(1);

        // 5b. Clear mid-HOLD with a full FIFO and overflow set
        push_word(16'hC0D0);
        for (int i = 1; i <= 5; i++) push_word(16'hC0D0 + 16'(i));
        check_val("t5_pre_ovf", 38'(ovf()), 38'd1);
        check_val("t5_pre_lvl", 38'(level()), 38'd4);
        la_oenb = OENB_NO_CLEAR;
        drive(16'h0000, 1'b0, 1'b1);
        cyc(1);
        check_val("t5_mclr_busy", 38'(busy()), 38'd1);
        check_val("t5_mclr_io", 38'(io_word()), 38'hC0D0);
        la_oenb = OENB_DRIVE;
        drive(16'hDEAD, 1'b1, 1'b1);                      // push edge during clear
        cyc(1);
        check_val("t5_clr_la_out", 38'(la_data_out), 38'h0);
        check_val("t5_clr_io", io_out, 38'h0);
        drive(16'hDEAD, 1'b1, 1'b0);                      // still high: no new edge
        cyc(2);
        check_val("t5_noedge_lvl", 38'(level()), 38'd0);
        check_val("t5_noedge_io", 38'(io_word()), 38'h0);
        drive(16'h0000, 1'b0, 1'b0);
        cyc(1);

        // 6. Async reset mid-HOLD with three queued
        push_word(16'h6000);
        push_word(16'h6001);
        push_word(16'h6002);
        push_word(16'h6003);
        check_val("t6_pre_lvl", 38'(level()), 38'd3);
        check_val("t6_pre_busy", 38'(busy()), 38'd1);
        #2 resetb = 1'b0;
        #1;
        check_val("t6_async_io", io_out, 38'h0);
        check_val("t6_async_la", 38'(la_data_out), 38'h0);
        check_val("t6_async_oeb", io_oeb, OEB_EXP);
        cyc(3);
        resetb = 1'b1;
        cyc(4);
        check_val("t6_rel_la", 38'(la_data_out), 38'h0);
        drive(16'h1234, 1'b1, 1'b0);
        cyc(1);                                           // N
        check_val("t6_n1_lvl", 38'(level()), 38'd1);
        check_val("t6_n1_io", 38'(io_word()), 38'h0);
        drive(16'h1234, 1'b0, 1'b0);
        cyc(1);                                           // N+1 edge
        check_val("t6_n2_io", 38'(io_word()), 38'h1234);
        check_val("t6_n2_busy", 38'(busy()), 38'd1);

        // ------------------------------------------------------------ report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
